// File: rtl/row_clear_engine.sv
// rtl/row_clear_engine.sv - bottom-up full-row detector and collapser for the playfield board
// Optional macro ROW_SCORE_EN adds a saturating 16-bit Score accumulator.
module row_clear_engine #(
  parameter int BLOCKS_WIDE = 14,
  parameter int BLOCKS_HIGH = 18,
  parameter int ROW_W       = 5,
  parameter int CNT_W       = 5
) (
  input  logic                               Clk,
  input  logic                               Rst_n,
  input  logic                               Pause,
  input  logic                               Start,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] Game_in,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] Game_out,
  output logic [ROW_W-1:0]                   Row,
  output logic                               Busy,
  output logic                               Done,
`ifdef ROW_SCORE_EN
  output logic [15:0]                        Score,
`endif
  output logic [CNT_W-1:0]                   Lines_cleared
);

  localparam int BW = BLOCKS_WIDE * BLOCKS_HIGH;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    board_q, board_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             row_full;

  always_comb begin
    row_full = &board_q[int'(row_q)*BLOCKS_WIDE +: BLOCKS_WIDE];
    state_d  = state_q;
    board_d  = board_q;
    row_d    = row_q;
    lines_d  = lines_q;
    if (!Pause) begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            board_d = Game_in;
            row_d   = ROW_W'(BLOCKS_HIGH - 1);
            lines_d = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (row_full)          state_d = SHIFT;
          else if (row_q == '0)  state_d = DONE;
          else                   row_d   = row_q - ROW_W'(1);
        end
        SHIFT: begin
          // Everything at or above the full row drops by one; top row refills empty.
          board_d[0 +: BLOCKS_WIDE] = '0;
          for (int r = 1; r < BLOCKS_HIGH; r++) begin
            if (r <= int'(row_q))
              board_d[r*BLOCKS_WIDE +: BLOCKS_WIDE] = board_q[(r-1)*BLOCKS_WIDE +: BLOCKS_WIDE];
          end
          lines_d = lines_q + CNT_W'(1);
          state_d = SCAN;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == SCAN) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      board_q <= '0;
      row_q   <= '0;
      lines_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      row_q   <= row_d;
      lines_q <= lines_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Game_out      = board_q;
  assign Row           = row_q;
  assign Busy          = busy_q;
  assign Done          = done_q;
  assign Lines_cleared = lines_q;

`ifdef ROW_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [15:0] bonus;
  logic [16:0] score_sum;

  always_comb begin
    if (lines_q >= CNT_W'(4))      bonus = 16'd8;
    else if (lines_q == CNT_W'(3)) bonus = 16'd5;
    else if (lines_q == CNT_W'(2)) bonus = 16'd3;
    else if (lines_q == CNT_W'(1)) bonus = 16'd1;
    else                           bonus = 16'd0;
    score_sum = {1'b0, score_q} + {1'b0, bonus};
    score_d   = score_q;
    if (!Pause && state_q == DONE)
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) score_q <= '0;
    else        score_q <= score_d;
  end

  assign Score = score_q;
`endif

endmodule

// File: tb/tb_row_clear_engine.sv
// tb/tb_row_clear_engine.sv - randomized self-checking bench for row_clear_engine against a row-list model
module tb_row_clear_engine;
  localparam int W  = 14;
  localparam int H  = 18;
  localparam int BW = W * H;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Pause = 1'b0;
  logic          Start = 1'b0;
  logic [BW-1:0] Game_in = '0;
  logic [BW-1:0] Game_out;
  logic [4:0]    Row;
  logic          Busy;
  logic          Done;
  logic [4:0]    Lines_cleared;
`ifdef ROW_SCORE_EN
  logic [15:0]   Score;
  int            score_m = 0;
`endif

  int checks   = 0;
  int failures = 0;

  row_clear_engine #(.BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .ROW_W(5), .CNT_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Pause(Pause), .Start(Start), .Game_in(Game_in),
    .Game_out(Game_out), .Row(Row), .Busy(Busy), .Done(Done),
`ifdef ROW_SCORE_EN
    .Score(Score),
`endif
    .Lines_cleared(Lines_cleared)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected result: drop every full row, stack the survivors at the bottom in order.
  task automatic model(input logic [BW-1:0] b, output logic [BW-1:0] o, output int n);
    logic [W-1:0] rowv;
    int k;
    o = '0;
    n = 0;
    k = H - 1;
    for (int r = H - 1; r >= 0; r--) begin
      rowv = b[r*W +: W];
      if (&rowv) n++;
      else begin
        o[k*W +: W] = rowv;
        k--;
      end
    end
  endtask

  function automatic logic [BW-1:0] rand_board();
    logic [BW-1:0] b;
    logic [W-1:0]  v;
    int            sel;
    b = '0;
    for (int r = 0; r < H; r++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      v = '1;
      else if (sel < 6) v = '0;
      else begin
        v = W'($urandom);
        if (&v) v[$urandom_range(0, W-1)] = 1'b0;
      end
      b[r*W +: W] = v;
    end
    return b;
  endfunction

  // pause_at > 0 freezes the engine for 5 cycles starting after that sample;
  // hold_done freezes it for 3 cycles while Done is showing.
  task automatic run_op(input string tag, input logic [BW-1:0] board, input int pause_at,
                        input bit hold_done, input bit noise);
    logic [BW-1:0] exp_b;
    int            n, cyc, busy_cnt, extra;
    bit            got;
    model(board, exp_b, n);
    extra    = (pause_at > 0) ? 5 : 0;
    Game_in  = board;
    Start    = 1'b1;
    cyc      = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (cyc < 300 && !got) begin
      @(posedge Clk); #1;
      cyc++;
      Start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      Game_in = noise ? rand_board() : Game_in;
      if (Busy) busy_cnt++;
      if (pause_at > 0 && cyc == pause_at)     Pause = 1'b1;
      if (pause_at > 0 && cyc == pause_at + 5) Pause = 1'b0;
      if (Done) got = 1'b1;
    end
    Start = 1'b0;
    chk({tag, "_done_seen"}, 256'(got), 256'(1));
    chk({tag, "_latency"}, 256'(cyc), 256'(H + 2*n + 1 + extra));
    chk({tag, "_busy_cycles"}, 256'(busy_cnt), 256'(H + 2*n + extra));
    chk({tag, "_board"}, 256'(Game_out), 256'(exp_b));
    chk({tag, "_lines"}, 256'(Lines_cleared), 256'(n));
    chk({tag, "_row"}, 256'(Row), 256'(0));
    if (hold_done) begin
      Pause = 1'b1;
      repeat (3) begin
        @(posedge Clk); #1;
        chk({tag, "_done_held"}, 256'(Done), 256'(1));
      end
      Pause = 1'b0;
    end
`ifdef ROW_SCORE_EN
    score_m = score_m + ((n >= 4) ? 8 : (n == 3) ? 5 : (n == 2) ? 3 : n);
    if (score_m > 65535) score_m = 65535;
`endif
    @(posedge Clk); #1;
    chk({tag, "_done_pulse_end"}, 256'(Done), 256'(0));
    chk({tag, "_busy_end"}, 256'(Busy), 256'(0));
`ifdef ROW_SCORE_EN
    chk({tag, "_score"}, 256'(Score), 256'(score_m));
`endif
    Game_in = ~board;
    repeat (2) @(posedge Clk);
    #1;
    chk({tag, "_board_hold"}, 256'(Game_out), 256'(exp_b));
  endtask

  function automatic logic [BW-1:0] with_row(input logic [BW-1:0] b, input int r, input logic [W-1:0] v);
    logic [BW-1:0] o;
    o = b;
    o[r*W +: W] = v;
    return o;
  endfunction

  initial begin
    logic [BW-1:0] b;
    bit            seen;

    #1;
    chk("reset_board", 256'(Game_out), 256'(0));
    chk("reset_flags", 256'({Busy, Done, Row, Lines_cleared}), 256'(0));
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk); #1;

    run_op("empty", '0, 0, 1'b0, 1'b0);

    b = with_row(with_row('0, 17, '1), 16, 14'h0001);
    run_op("one_row", b, 0, 1'b0, 1'b0);

    b = with_row(with_row(with_row(with_row('0, 17, '1), 16, 14'h2000), 15, '1), 14, 14'h0003);
    run_op("two_rows", b, 0, 1'b0, 1'b0);

    run_op("all_full", '1, 0, 1'b0, 1'b0);

    b = with_row(with_row('0, 17, '1), 16, 14'h0001);
    run_op("pause_scan", b, 3, 1'b0, 1'b0);

    run_op("pause_done", with_row('0, 9, '1), 0, 1'b1, 1'b0);

    // Abort in the first SHIFT cycle of an all-full board.
    Game_in = '1;
    Start   = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("abort_busy_before", 256'(Busy), 256'(1));
    Rst_n = 1'b0;
    #1;
    chk("abort_board", 256'(Game_out), 256'(0));
    chk("abort_flags", 256'({Busy, Done, Row, Lines_cleared}), 256'(0));
`ifdef ROW_SCORE_EN
    score_m = 0;
    chk("abort_score", 256'(Score), 256'(0));
`endif
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen = 1'b1;
    end
    chk("abort_stays_idle", 256'(seen), 256'(0));

    for (int i = 0; i < 30; i++)
      run_op("rand", rand_board(), (i % 5 == 0) ? int'($urandom_range(2, 12)) : 0,
             (i % 7 == 3), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
